// File: rtl/md_seq_unit.sv
// Multi-cycle multiply/divide sequencer owning HI/LO: shift-add multiply, restoring divide, one sign-fix cycle.
// Build option MD_EARLY_OUT_EN: multiply leaves CALC as soon as the remaining multiplier bits are zero.
module md_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] tg,
  input  logic             cancel,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 dz_q, dz_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dzf_q, dzf_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     sr_abs, tg_abs;
  logic [WIDTH:0]       mul_sum, div_shf, div_try;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt, acc_fix, prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;
  logic                 mul_last;

  assign signed_op = ~op[0];
  assign sr_abs    = (signed_op && sr[WIDTH-1]) ? -sr : sr;
  assign tg_abs    = (signed_op && tg[WIDTH-1]) ? -tg : tg;

  // acc = {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_shf = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_try = div_shf - {1'b0, opnd_q};
  assign div_nxt = div_try[WIDTH] ? {div_shf[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_try[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef MD_EARLY_OUT_EN
  logic [WIDTH-1:0] rem_mask;
  assign rem_mask = ~({WIDTH{1'b1}} << cnt_q);
  assign mul_last = (cnt_q == '0) || ((mul_nxt[WIDTH-1:0] & rem_mask) == '0);
  // Skipped steps would only have shifted right; cnt_q holds how many remain.
  assign acc_fix  = is_div_q ? acc_q : (acc_q >> cnt_q);
`else
  assign mul_last = (cnt_q == '0);
  assign acc_fix  = acc_q;
`endif

  assign prod_fix = neg_q  ? -acc_fix : acc_fix;
  assign quot_fix = neg_q  ? -acc_fix[WIDTH-1:0] : acc_fix[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -acc_fix[2*WIDTH-1:WIDTH] : acc_fix[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dzf_d    = dzf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          if (!op[2]) begin
            state_d  = S_CALC;
            cnt_d    = CW'(WIDTH - 1);
            is_div_d = op[1];
            dz_d     = op[1] && (tg == '0);
            neg_d    = signed_op && (sr[WIDTH-1] ^ tg[WIDTH-1]);
            rneg_d   = signed_op && op[1] && sr[WIDTH-1];
            dzf_d    = 1'b0;
            if (!op[1]) begin
              acc_d  = {{WIDTH{1'b0}}, tg_abs};
              opnd_d = sr_abs;
            end else begin
              // divide-by-zero keeps the raw dividend so FIX can return it in HI
              acc_d  = {{WIDTH{1'b0}}, (tg == '0) ? sr : sr_abs};
              opnd_d = tg_abs;
            end
          end else if (op == 3'd4) begin
            hi_d = sr;
          end else if (op == 3'd5) begin
            lo_d = sr;
          end
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (dz_q) begin
          state_d = S_FIX;
        end else if (is_div_q) begin
          acc_d = div_nxt;
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CW'(1);
        end else begin
          acc_d = mul_nxt;
          if (mul_last) state_d = S_FIX;
          else          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d  = acc_q[WIDTH-1:0];
            lo_d  = '1;
            dzf_d = 1'b1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dzf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dzf_q    <= dzf_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dzf_q;

endmodule

// File: tb/tb_md_seq_unit.sv
// Scoreboard bench for md_seq_unit: driver pushes reference results, a done-triggered monitor pops and compares.
module tb_md_seq_unit;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cancel = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  sr = '0;
  logic [W-1:0]  tg = '0;
  logic          ready, busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  md_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sr(sr), .tg(tg),
    .cancel(cancel), .ready(ready), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned cyc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned bcnt = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      p, q, r;
    logic [63:0] res;
    logic [31:0] mag;
    int unsigned k;
    res   = '0;
    e.dz  = 1'b0;
    e.cyc = 0;
    e.lat = W + 1;
    case (o)
      3'd0: begin p = longint'(signed'(a)) * longint'(signed'(b)); res = p; end
      3'd1: res = {32'b0, a} * {32'b0, b};
      3'd2: if (b != 0) begin
              q = longint'(signed'(a)) / longint'(signed'(b));
              r = longint'(signed'(a)) % longint'(signed'(b));
              res = {r[31:0], q[31:0]};
            end
      default: if (b != 0) res = {a % b, a / b};
    endcase
    e.hi = res[63:32];
    e.lo = res[31:0];
    if (o[1] && b == 0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dz  = 1'b1;
      e.lat = 2;
    end
`ifdef MD_EARLY_OUT_EN
    if (!o[1]) begin
      mag = (o == 3'd0 && b[31]) ? -b : b;
      k = 0;
      while (k < 32 && (mag >> k) != 0) k++;
      if (k == 0) k = 1;
      e.lat = k + 1;
    end
`endif
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: done pops the scoreboard; busy cycles since acceptance give the latency
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("result_hi", hi, e.hi);
          check("result_lo", lo, e.lo);
          check("div_zero", div_zero, e.dz);
          check("done_cycle", cyc, e.cyc);
          check("busy_cycles", bcnt, e.lat);
        end
      end
      if (ready) bcnt = 0;
    end
  end

  task automatic wait_ready();
    int unsigned n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit will_abort);
    exp_t e;
    wait_ready();
    start = 1'b1;
    op    = o;
    sr    = a;
    tg    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (o <= 3'd3) begin
      check("busy_after_accept", busy, 1);
      check("dz_cleared_on_accept", div_zero, 0);
      if (!will_abort) begin
        e     = model(o, a, b);
        e.cyc = cyc + e.lat;
        sb.push_back(e);
        m_hi  = e.hi;
        m_lo  = e.lo;
      end
    end else if (o == 3'd4) begin
      m_hi = a;
      check("mthi_hi", hi, m_hi);
      check("mthi_busy", {busy, done}, 0);
    end else if (o == 3'd5) begin
      m_lo = a;
      check("mtlo_lo", lo, m_lo);
      check("mtlo_busy", {busy, done}, 0);
    end else begin
      check("reserved_hilo", {hi, lo}, {m_hi, m_lo});
      check("reserved_ready", ready, 1);
    end
  endtask

  initial begin
    logic [31:0] ph, pl;
    int unsigned n;
    #12;
    check("reset_ready", ready, 1);
    check("reset_busy_done_dz", {busy, done, div_zero}, 0);
    check("reset_hilo", {hi, lo}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(3'd0, 32'hFFFF_FFFB, 32'h3, 0);
    issue(3'd2, 32'hFFFF_FFF0, 32'h3, 0);
    issue(3'd3, 32'h10, 32'h3, 0);
    issue(3'd3, 32'h1234, 32'h0, 0);
    issue(3'd1, 32'h7, 32'h9, 0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(3'd4, 32'hAAAA_5555, 32'h0, 0);
    issue(3'd5, 32'h0F0F_0F0F, 32'h0, 0);
    issue(3'd6, $urandom(), $urandom(), 0);

    // second start while a MULT runs must be dropped
    ph = m_hi;
    pl = m_lo;
    issue(3'd0, $urandom(), 32'h4000_0000 | ($urandom() & 32'h3FFF_FFFF), 0);
    repeat (4) @(negedge clk);
    check("busy_blocks_ready", ready, 0);
    start = 1'b1;
    op    = 3'($urandom_range(0, 5));
    sr    = $urandom();
    tg    = $urandom();
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_start_hilo", {hi, lo}, {ph, pl});
    check("ignored_start_busy", busy, 1);

    // cancel at cycle 10: no commit, no done
    wait_ready();
    ph = m_hi;
    pl = m_lo;
    issue(3'd0, $urandom(), 32'h4000_0000 | ($urandom() & 32'h3FFF_FFFF), 1);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_ready", ready, 1);
    check("cancel_busy_done", {busy, done}, 0);
    check("cancel_hilo", {hi, lo}, {ph, pl});
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 6)), pick(), pick(), 0);
    end

    // asynchronous reset in the middle of a divide
    issue(3'd2, $urandom(), $urandom() | 32'h1, 1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midop_reset_ready", ready, 1);
    check("midop_reset_busy_done_dz", {busy, done, div_zero}, 0);
    check("midop_reset_hilo", {hi, lo}, 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(3'd1, $urandom(), $urandom(), 0);
    issue(3'd0, pick(), pick(), 0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    @(negedge clk);
    check("final_hilo", {hi, lo}, {m_hi, m_lo});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
